vtg_timing: RTL and testbench

Parametrised raster timing generator: the second-generation sync/visible-window source for TheBoard video outputs. Produces hsync/vsync with configurable polarity, a display-enable window, pixel/line addresses with configurable fetch lead, and line/frame strobes for downstream fetch and palette logic. It supports any mode fitting the counter width, plus a synchronous run/stop control. An optional line-compare interrupt is compiled in by macro.

---
 rtl/vtg_timing.sv | 217 +++++++++++++++++++++
 tb/tb_vtg_timing.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vtg_timing.sv
// ---------------------------------------------------------------------------
// vtg_timing -- parametrised raster timing generator
//
// Generates horizontal/vertical sync with configurable polarity, a
// display-enable window, pixel/line addresses (pixel address leads the
// visible window by LEAD clocks so fetch logic can prefetch), and
// start-of-line / start-of-frame strobes.
//
// Line layout on hcnt:  front porch | sync | back porch | visible
// Frame layout on vcnt: front porch | sync | back porch | visible
// hcnt == 0 is the first front-porch pixel, vcnt == 0 the first
// front-porch line.
//
// Optional feature: define VTG_LINE_IRQ_EN to build the line-compare
// interrupt (line_cmp input, line_irq output). Without the macro those
// ports and the compare logic do not exist.
//
// Ports
//   clk       in   pixel clock
//   rst_n     in   asynchronous active-low reset
//   en        in   run (1) / stop (0); registered once into run_q
//   line_cmp  in   [CNT_W] interrupt line, in vaddr space   (macro only)
//   hsync     out  horizontal sync, active level HPOL
//   vsync     out  vertical sync, active level VPOL
//   de        out  display enable, high inside the visible window
//   haddr     out  [CNT_W] hcnt - HSTART + LEAD, modulo 2^CNT_W
//   vaddr     out  [CNT_W] vcnt - VSTART, modulo 2^CNT_W
//   sol       out  start-of-line pulse (hcnt == 0 while running)
//   sof       out  start-of-frame pulse (sol with vcnt == 0)
//   line_irq  out  line-compare pulse                       (macro only)
// ---------------------------------------------------------------------------
module vtg_timing #(
    parameter int unsigned HFRONT  = 48,
    parameter int unsigned HSYNC   = 112,
    parameter int unsigned HBACK   = 248,
    parameter int unsigned HACTIVE = 1280,
    parameter int unsigned VFRONT  = 1,
    parameter int unsigned VSYNC   = 3,
    parameter int unsigned VBACK   = 38,
    parameter int unsigned VACTIVE = 1024,
    parameter bit          HPOL    = 1'b0,
    parameter bit          VPOL    = 1'b0,
    parameter int unsigned LEAD    = 2,
    parameter int unsigned CNT_W   = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
`ifdef VTG_LINE_IRQ_EN
    input  logic [CNT_W-1:0] line_cmp,
    output logic             line_irq,
`endif
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] haddr,
    output logic [CNT_W-1:0] vaddr,
    output logic             sol,
    output logic             sof
);

    // -----------------------------------------------------------------------
    // Derived timing constants, all pre-sized to the counter width so every
    // compare below is width-matched.
    // -----------------------------------------------------------------------
    localparam int unsigned HSTART = HFRONT + HSYNC + HBACK;
    localparam int unsigned HTOTAL = HSTART + HACTIVE;
    localparam int unsigned VSTART = VFRONT + VSYNC + VBACK;
    localparam int unsigned VTOTAL = VSTART + VACTIVE;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HTOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_B = CNT_W'(HFRONT);
    localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(HFRONT + HSYNC);
    localparam logic [CNT_W-1:0] H_START  = CNT_W'(HSTART);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VTOTAL - 1);
    localparam logic [CNT_W-1:0] V_SYNC_B = CNT_W'(VFRONT);
    localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(VFRONT + VSYNC);
    localparam logic [CNT_W-1:0] V_START  = CNT_W'(VSTART);
    // LEAD <= HBACK <= HSTART, so this offset is never negative.
    localparam logic [CNT_W-1:0] H_ADDR_OFS = CNT_W'(HSTART - LEAD);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic             run_q,   run_d;
    logic [CNT_W-1:0] hcnt_q,  hcnt_d;
    logic [CNT_W-1:0] vcnt_q,  vcnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q,    de_d;
    logic             sol_q,   sol_d;
    logic             sof_q,   sof_d;

    // Decoded window flags for the next counter values.
    logic hs_act;
    logic vs_act;

    // -----------------------------------------------------------------------
    // Next-state: counters
    //
    // run_d is simply en. While stopping (en low) the counters clear on the
    // very next clock with no line completion. On the first clock of a run
    // (run_q still low) the counters are forced to 0 so the frame starts
    // clean with sof asserted in the same cycle run_q rises.
    // -----------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        run_d  = en;
        hcnt_d = '0;
        vcnt_d = '0;
        if (en && run_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                // vcnt only moves on the clock hcnt wraps, so anything
                // decoded from it switches on line boundaries.
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CNT_ONE;
            end else begin
                hcnt_d = hcnt_q + CNT_ONE;
                vcnt_d = vcnt_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state: outputs
    //
    // All strobes are decoded from the *next* counter values and registered,
    // so each registered output lines up exactly with the counter value it
    // describes -- no skew between hcnt/vcnt (and hence haddr/vaddr) and the
    // syncs, de and strobes.
    // -----------------------------------------------------------------------
    always_comb begin
        hs_act  = run_d && (hcnt_d >= H_SYNC_B) && (hcnt_d < H_SYNC_E);
        vs_act  = run_d && (vcnt_d >= V_SYNC_B) && (vcnt_d < V_SYNC_E);

        hsync_d = hs_act ? HPOL : ~HPOL;
        vsync_d = vs_act ? VPOL : ~VPOL;
        de_d    = run_d && (hcnt_d >= H_START) && (vcnt_d >= V_START);
        sol_d   = run_d && (hcnt_d == '0);
        sof_d   = sol_d && (vcnt_d == '0);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            hsync_q <= ~HPOL;
            vsync_q <= ~VPOL;
            de_q    <= 1'b0;
            sol_q   <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            run_q   <= run_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            sol_q   <= sol_d;
            sof_q   <= sof_d;
        end
    end

`ifdef VTG_LINE_IRQ_EN
    // -----------------------------------------------------------------------
    // Line-compare interrupt
    //
    // One-clock pulse in the cycle hcnt == HSTART on the visible line whose
    // vaddr equals line_cmp. line_cmp is compared against the next-count
    // line address, so it is picked up fresh for every line and a change
    // only affects lines not yet reached. A line_cmp >= VACTIVE can never
    // match because visible vaddr stays below VACTIVE.
    // -----------------------------------------------------------------------
    logic line_irq_q, line_irq_d;

    always_comb begin
        line_irq_d = run_d
                  && (hcnt_d == H_START)
                  && (vcnt_d >= V_START)
                  && ((vcnt_d - V_START) == line_cmp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_irq_q <= 1'b0;
        end else begin
            line_irq_q <= line_irq_d;
        end
    end

    assign line_irq = line_irq_q;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    //
    // Addresses are plain modular differences of the counters: meaningful
    // inside the window, wrapped (not clamped) elsewhere.
    // -----------------------------------------------------------------------
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign de    = de_q;
    assign sol   = sol_q;
    assign sof   = sof_q;
    assign haddr = hcnt_q - H_ADDR_OFS;
    assign vaddr = vcnt_q - V_START;

endmodule

// File: tb/tb_vtg_timing.sv
// ---------------------------------------------------------------------------
// tb_vtg_timing -- self-checking bench for vtg_timing
//
// Small mode: HFRONT=2 HSYNC=3 HBACK=4 HACTIVE=8 (HTOTAL=17, HSTART=9),
//             VFRONT=1 VSYNC=2 VBACK=2 VACTIVE=4 (VTOTAL=9, VSTART=5),
//             LEAD=2.
// Two instances share all inputs: u_dut_n with active-low syncs and u_dut_p
// with active-high syncs.
//
// The stimulus process drives en/rst_n one clock at a time and pushes the
// expected output state after that clock into a queue; the monitor pops one
// entry at each falling edge and compares. Directed spot checks for the
// boundaries are done inline by the stimulus process.
// ---------------------------------------------------------------------------
module tb_vtg_timing;

    localparam int HT = 17;   // HTOTAL
    localparam int VT = 9;    // VTOTAL

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [10:0] line_cmp;

    logic        hsync_n, vsync_n, de_n, sol_n, sof_n, irq_n;
    logic [10:0] haddr_n, vaddr_n;
    logic        hsync_p, vsync_p, de_p, sol_p, sof_p, irq_p;
    logic [10:0] haddr_p, vaddr_p;

    vtg_timing #(
        .HFRONT(2), .HSYNC(3), .HBACK(4), .HACTIVE(8),
        .VFRONT(1), .VSYNC(2), .VBACK(2), .VACTIVE(4),
        .HPOL(1'b0), .VPOL(1'b0), .LEAD(2), .CNT_W(11)
    ) u_dut_n (
        .clk(clk), .rst_n(rst_n), .en(en),
`ifdef VTG_LINE_IRQ_EN
        .line_cmp(line_cmp), .line_irq(irq_n),
`endif
        .hsync(hsync_n), .vsync(vsync_n), .de(de_n),
        .haddr(haddr_n), .vaddr(vaddr_n), .sol(sol_n), .sof(sof_n)
    );

    vtg_timing #(
        .HFRONT(2), .HSYNC(3), .HBACK(4), .HACTIVE(8),
        .VFRONT(1), .VSYNC(2), .VBACK(2), .VACTIVE(4),
        .HPOL(1'b1), .VPOL(1'b1), .LEAD(2), .CNT_W(11)
    ) u_dut_p (
        .clk(clk), .rst_n(rst_n), .en(en),
`ifdef VTG_LINE_IRQ_EN
        .line_cmp(line_cmp), .line_irq(irq_p),
`endif
        .hsync(hsync_p), .vsync(vsync_p), .de(de_p),
        .haddr(haddr_p), .vaddr(vaddr_p), .sol(sol_p), .sof(sof_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Check bookkeeping
    // -----------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    typedef struct packed {
        logic        hs;      // hsync pulse active
        logic        vs;      // vsync pulse active
        logic        de;
        logic        sol;
        logic        sof;
        logic        irq;
        logic [10:0] haddr;
        logic [10:0] vaddr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Period measurement, enabled only over an uninterrupted run.
    bit measure  = 1'b0;
    int cyc      = 0;
    int last_sol = -1;
    int last_sof = -1;

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("hsync_lo",  hsync_n, !mon_e.hs);
            check("vsync_lo",  vsync_n, !mon_e.vs);
            check("hsync_hi",  hsync_p,  mon_e.hs);
            check("vsync_hi",  vsync_p,  mon_e.vs);
            check("de",        de_n,     mon_e.de);
            check("de_p",      de_p,     mon_e.de);
            check("sol",       sol_n,    mon_e.sol);
            check("sof",       sof_n,    mon_e.sof);
            check("haddr",     haddr_n,  mon_e.haddr);
            check("vaddr",     vaddr_n,  mon_e.vaddr);
            check("sof_p",     sof_p,    mon_e.sof);
`ifdef VTG_LINE_IRQ_EN
            check("line_irq",  irq_n,    mon_e.irq);
            check("line_irq_p", irq_p,   mon_e.irq);
`endif
        end
        if (measure) begin
            if (sol_n) begin
                if (last_sol >= 0) check("sol_period", cyc - last_sol, 17);
                last_sol = cyc;
            end
            if (sof_n) begin
                if (last_sof >= 0) check("sof_period", cyc - last_sof, 153);
                last_sof = cyc;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Expected-state tracker: position of the raster after each clock.
    // -----------------------------------------------------------------------
    bit m_run = 1'b0;
    int m_h   = 0;
    int m_v   = 0;

    // Drive en for one clock, push the expected state after that clock,
    // and return 1 time unit after the following falling edge.
    task automatic step(input logic en_v);
        exp_t e;
        en = en_v;
        if (!en_v) begin
            m_run = 1'b0; m_h = 0; m_v = 0;
        end else if (!m_run) begin
            m_run = 1'b1; m_h = 0; m_v = 0;
        end else begin
            m_h++;
            if (m_h == HT) begin
                m_h = 0;
                m_v++;
                if (m_v == VT) m_v = 0;
            end
        end
        e.hs    = m_run && (m_h >= 2) && (m_h < 5);
        e.vs    = m_run && (m_v >= 1) && (m_v < 3);
        e.de    = m_run && (m_h >= 9) && (m_v >= 5);
        e.sol   = m_run && (m_h == 0);
        e.sof   = e.sol && (m_v == 0);
        e.irq   = m_run && (m_h == 9) && (m_v >= 5) && ((m_v - 5) == int'(line_cmp));
        e.haddr = 11'(m_h - 7);     // hcnt - HSTART + LEAD
        e.vaddr = 11'(m_v - 5);     // vcnt - VSTART
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic run_until(input int h, input int v);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (m_run && m_h == h && m_v == v) begin
                hit = 1'b1;
                break;
            end
            step(1'b1);
        end
        check("reach_point", hit, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_hsync_lo"}, hsync_n, 1);
        check({tag, "_vsync_lo"}, vsync_n, 1);
        check({tag, "_hsync_hi"}, hsync_p, 0);
        check({tag, "_vsync_hi"}, vsync_p, 0);
        check({tag, "_de"},       de_n,    0);
        check({tag, "_sol"},      sol_n,   0);
        check({tag, "_sof"},      sof_n,   0);
        check({tag, "_haddr"},    haddr_n, 2041);   // -7 mod 2048
        check({tag, "_vaddr"},    vaddr_n, 2043);   // -5 mod 2048
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        line_cmp = 11'd2;
        repeat (3) @(negedge clk);
        #1;
        check_idle("reset");
`ifdef VTG_LINE_IRQ_EN
        check("reset_irq", irq_n, 0);
`endif

        // Out of reset but stopped: everything stays idle.
        rst_n = 1'b1;
        step(1'b0);
        step(1'b0);
        check_idle("stopped");

        // Two full frames from a clean start, with boundary spot checks.
        measure = 1'b1;
        step(1'b1);
        check("start_sof",   sof_n,   1);
        check("start_haddr", haddr_n, 2041);
        for (int i = 0; i < 2 * 153 + 1; i++) begin
            step(1'b1);
            if (m_h == 7 && m_v == 5) check("haddr_lead_zero", haddr_n, 0);
            if (m_h == 8 && m_v == 5) check("de_before_win",   de_n,    0);
            if (m_h == 9 && m_v == 5) begin
                check("first_de",       de_n,    1);
                check("first_de_haddr", haddr_n, 2);
                check("first_de_vaddr", vaddr_n, 0);
            end
            if (m_h == 16 && m_v == 8) check("last_de",    de_n,    1);
            if (m_h == 9  && m_v == 4) check("de_vback",   de_n,    0);
            if (m_h == 4  && m_v == 0) check("hsync_last", hsync_n, 0);
            if (m_h == 5  && m_v == 0) check("hsync_end",  hsync_n, 1);
        end
        measure = 1'b0;

        // en dropped at hcnt=6, vcnt=3 for 5 clocks, then raised.
        run_until(6, 3);
        step(1'b0);
        check_idle("drop");
        repeat (4) step(1'b0);
        step(1'b1);
        check("restart_sof",   sof_n,   1);
        check("restart_haddr", haddr_n, 2041);
        check("restart_vaddr", vaddr_n, 2043);

        // Drop in the middle of both sync pulses: syncs must go idle.
        run_until(3, 1);
        check("in_hsync", hsync_n, 0);
        check("in_vsync", vsync_n, 0);
        step(1'b0);
        check_idle("drop_sync");
        step(1'b1);
        repeat (20) step(1'b1);

        // Asynchronous reset mid-visible at hcnt=12.
        run_until(12, 6);
        check("pre_reset_de", de_n, 1);
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        m_run = 1'b0; m_h = 0; m_v = 0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1);
        check("rst_release_sof", sof_n, 1);

`ifdef VTG_LINE_IRQ_EN
        // Line-compare interrupt: line 2 fires once per frame at vcnt=7,
        // hcnt=9; line 4 (== VACTIVE) never fires.
        begin
            int irq_cnt;
            run_until(0, 0);
            line_cmp = 11'd2;
            irq_cnt  = 0;
            for (int i = 0; i < 153; i++) begin
                step(1'b1);
                if (irq_n) begin
                    irq_cnt++;
                    check("irq_hpos", m_h, 9);
                    check("irq_vpos", m_v, 7);
                end
            end
            check("irq_count_cmp2", irq_cnt, 1);
            line_cmp = 11'd4;
            irq_cnt  = 0;
            for (int i = 0; i < 153; i++) begin
                step(1'b1);
                if (irq_n) irq_cnt++;
            end
            check("irq_count_cmp4", irq_cnt, 0);
        end
`endif

        // Let the monitor drain the last entry.
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
